// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-N stream demultiplexer.
// One holding register (full/dst/dreg/lreg) sits between the producer and
// the N consumers. The destination is captured on the first beat of a packet
// and held until the last beat is accepted; packets addressed to a channel
// that does not exist are swallowed and counted in drop_cnt.
//
// Handshake: a beat moves across an interface in any cycle where valid and
// ready are both high on the rising edge. in_ready never depends on
// in_valid, in_data or in_last; a presented out_valid/out_data/out_last stays
// stable until its ready is seen.
module stream_demux_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_last,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_last,
    output logic [15:0]          drop_cnt,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

    // One extra bit so N itself (e.g. 256 with SELW=8) is representable.
    localparam logic [SELW:0] N_L = (SELW+1)'(N);

    state_t            state;
    logic              full;
    logic [SELW-1:0]   dst;
    logic [WIDTH-1:0]  dreg;
    logic              lreg;

    logic sel_bad;
    logic drain;
    logic accept;
    logic load;

    // Ready/accept decode: an invalid select on a packet start, or any beat
    // of a dropped packet, is consumed without touching the holding register.
    always_comb begin
        sel_bad  = (state == IDLE) && ({1'b0, in_sel} >= N_L);
        drain    = full && out_ready[dst];
        in_ready = (state == DROP) || sel_bad || !full || drain;
        accept   = in_valid && in_ready;
        load     = accept && (state != DROP) && !sel_bad;
    end

    // Packet FSM, holding register and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            full     <= 1'b0;
            dst      <= '0;
            dreg     <= '0;
            lreg     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // A load in the same cycle as a drain keeps full set and
            // overwrites the register (dst included) with the new beat.
            if (load) begin
                full <= 1'b1;
                dreg <= in_data;
                lreg <= in_last;
                if (state == IDLE) begin
                    dst <= in_sel;
                end
            end else if (drain) begin
                full <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (sel_bad) begin
                            if (drop_cnt != 16'hFFFF) begin
                                drop_cnt <= drop_cnt + 16'd1;
                            end
                            state <= in_last ? IDLE : DROP;
                        end else begin
                            state <= in_last ? IDLE : PKT;
                        end
                    end
                    PKT: begin
                        if (in_last) begin
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (in_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Fan the holding register out to the selected channel; others read 0.
    always_comb begin
        out_valid = '0;
        out_last  = '0;
        out_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (full && (dst == SELW'(i))) begin
                out_valid[i]              = 1'b1;
                out_last[i]               = lreg;
                out_data[i*WIDTH +: WIDTH] = dreg;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Testbench for stream_demux_1ton: an N=8 instance driven from a table of
// per-cycle vectors, plus an N=6 instance for invalid-select dropping and a
// hand-written mid-cycle reset sequence.
module tb_stream_demux_1ton;

    logic clk;
    logic rst_n;

    // N=8, WIDTH=8 instance
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_last;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_last;
    logic [15:0] drop_cnt;
    logic [1:0]  state_dbg;

    // N=6, WIDTH=8 instance
    logic        in_valid6;
    logic        in_ready6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic        in_last6;
    logic [5:0]  out_valid6;
    logic [5:0]  out_ready6;
    logic [47:0] out_data6;
    logic [5:0]  out_last6;
    logic [15:0] drop_cnt6;
    logic [1:0]  state_dbg6;

    int total;
    int bad;

    stream_demux_1ton #(.WIDTH(8), .N(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
    );

    stream_demux_1ton #(.WIDTH(8), .N(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
        .in_sel(in_sel6), .in_last(in_last6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .out_last(out_last6), .drop_cnt(drop_cnt6), .state_dbg(state_dbg6)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  sel;
        logic [7:0]  d;
        logic        l;
        logic [7:0]  ordy;
        logic        e_rdy;
        logic [7:0]  e_ov;
        logic [63:0] e_od;
        logic [7:0]  e_ol;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Build one vector; e_ch < 0 means no channel is expected to be valid.
    function automatic vec_t mk(input logic v, input int sel, input int d, input logic l,
                                input logic [7:0] ordy, input logic e_rdy,
                                input int e_ch, input int e_d, input logic e_l);
        vec_t r;
        r.v     = v;
        r.sel   = 3'(sel);
        r.d     = 8'(d);
        r.l     = l;
        r.ordy  = ordy;
        r.e_rdy = e_rdy;
        r.e_ov  = '0;
        r.e_od  = '0;
        r.e_ol  = '0;
        if (e_ch >= 0) begin
            r.e_ov[e_ch]        = 1'b1;
            r.e_od[e_ch*8 +: 8] = 8'(e_d);
            r.e_ol[e_ch]        = e_l;
        end
        return r;
    endfunction

    // Drive one vector just after a rising edge, check in_ready before the
    // next edge, then check the registered outputs just after it.
    task automatic apply(input vec_t t, input int idx);
        in_valid  = t.v;
        in_sel    = t.sel;
        in_data   = t.d;
        in_last   = t.l;
        out_ready = t.ordy;
        @(negedge clk);
        chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(t.e_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(t.e_ov));
        chk($sformatf("v%0d out_data", idx), out_data, t.e_od);
        chk($sformatf("v%0d out_last", idx), 64'(out_last), 64'(t.e_ol));
    endtask

    task automatic step6(input string name, input int sel, input int d, input logic l,
                         input logic e_rdy, input logic [5:0] e_ov, input logic [47:0] e_od,
                         input int e_drop, input logic [1:0] e_state);
        in_valid6 = 1'b1;
        in_sel6   = 3'(sel);
        in_data6  = 8'(d);
        in_last6  = l;
        @(negedge clk);
        chk({name, " in_ready6"}, 64'(in_ready6), 64'(e_rdy));
        @(posedge clk);
        #1;
        in_valid6 = 1'b0;
        chk({name, " out_valid6"}, 64'(out_valid6), 64'(e_ov));
        chk({name, " out_data6"}, 64'(out_data6), 64'(e_od));
        chk({name, " drop_cnt6"}, 64'(drop_cnt6), 64'(e_drop));
        chk({name, " state6"}, 64'(state_dbg6), 64'(e_state));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        in_valid = 0; in_sel = 0; in_data = 0; in_last = 0; out_ready = 8'hFF;
        in_valid6 = 0; in_sel6 = 0; in_data6 = 0; in_last6 = 0; out_ready6 = 6'h3F;

        // ---- vector table ----
        // Single-beat packets to every channel, back to back.
        for (int s = 0; s < 8; s++) begin
            tbl.push_back(mk(1, s, 8'hA0 + s, 1, 8'hFF, 1, s, 8'hA0 + s, 1));
        end
        tbl.push_back(mk(0, 0, 0, 0, 8'hFF, 1, -1, 0, 0));
        // 4-beat packet to 5 with in_sel wandering to 2 mid-packet, then sel 2.
        tbl.push_back(mk(1, 5, 8'h51, 0, 8'hFF, 1, 5, 8'h51, 0));
        tbl.push_back(mk(1, 2, 8'h52, 0, 8'hFF, 1, 5, 8'h52, 0));
        tbl.push_back(mk(1, 2, 8'h53, 0, 8'hFF, 1, 5, 8'h53, 0));
        tbl.push_back(mk(1, 2, 8'h54, 1, 8'hFF, 1, 5, 8'h54, 1));
        tbl.push_back(mk(1, 2, 8'h22, 1, 8'hFF, 1, 2, 8'h22, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'hFF, 1, -1, 0, 0));
        // Backpressure on channel 3 for three cycles.
        tbl.push_back(mk(1, 3, 8'h31, 0, 8'hF7, 1, 3, 8'h31, 0));
        tbl.push_back(mk(1, 3, 8'h32, 0, 8'hF7, 0, 3, 8'h31, 0));
        tbl.push_back(mk(1, 3, 8'h32, 0, 8'hF7, 0, 3, 8'h31, 0));
        tbl.push_back(mk(1, 3, 8'h32, 0, 8'hF7, 0, 3, 8'h31, 0));
        tbl.push_back(mk(1, 3, 8'h32, 0, 8'hFF, 1, 3, 8'h32, 0));
        tbl.push_back(mk(1, 3, 8'h33, 1, 8'hFF, 1, 3, 8'h33, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'hFF, 1, -1, 0, 0));
        // Back-to-back packets to 1 then 4, no bubble.
        tbl.push_back(mk(1, 1, 8'h11, 0, 8'hFF, 1, 1, 8'h11, 0));
        tbl.push_back(mk(1, 1, 8'h12, 1, 8'hFF, 1, 1, 8'h12, 1));
        tbl.push_back(mk(1, 4, 8'h41, 0, 8'hFF, 1, 4, 8'h41, 0));
        tbl.push_back(mk(1, 4, 8'h42, 1, 8'hFF, 1, 4, 8'h42, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'hFF, 1, -1, 0, 0));

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;

        // ---- table run on the N=8 instance ----
        foreach (tbl[i]) begin
            apply(tbl[i], i);
        end
        chk("drop_cnt8 stays 0", 64'(drop_cnt), 64'd0);

        // ---- N=6: invalid selects are swallowed and counted ----
        step6("d7a", 7, 8'h71, 0, 1, 6'h00, 48'h0, 1, 2'd2);
        step6("d7b", 0, 8'h72, 0, 1, 6'h00, 48'h0, 1, 2'd2);
        step6("d7c", 0, 8'h73, 1, 1, 6'h00, 48'h0, 1, 2'd0);
        step6("d6",  6, 8'h61, 1, 1, 6'h00, 48'h0, 2, 2'd0);
        step6("s1",  1, 8'h15, 1, 1, 6'h02, 48'h1500, 2, 2'd0);
        @(posedge clk);
        #1;
        chk("n6 drained", 64'(out_valid6), 64'd0);

        // ---- mid-cycle reset truncates a packet ----
        in_valid = 1; in_sel = 3'd3; in_data = 8'h3C; in_last = 0; out_ready = 8'h00;
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("pre-rst out_valid", 64'(out_valid), 64'h08);
        chk("pre-rst in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst out_data", out_data, 64'd0);
        chk("midrst out_last", 64'(out_last), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst drop_cnt6", 64'(drop_cnt6), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // The next beat is a packet start, so its select is honoured.
        apply(mk(1, 2, 8'h2D, 1, 8'hFF, 1, 2, 8'h2D, 1), 100);
        apply(mk(0, 0, 0, 0, 8'hFF, 1, -1, 0, 0), 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1toN

Registered 1-to-N stream demultiplexer with valid/ready handshaking and packet-locked routing. It is the parametrised successor to the fixed 1-to-2/4/8 demuxes: WIDTH-bit beats arriving on one input stream are steered to one of N output channels. The destination is sampled on the first beat of each packet and held until the beat flagged `in_last` is accepted. It sits between a single producer and N independent consumers and provides one pipeline stage with full throughput and backpressure.

## Interface
- `WIDTH`, 8: data bits per beat (≥1)
- `N`, 8: number of output channels (2..256; need not be a power of 2)
- `SELW`, $clog2(N): select width (derived; do not override)
- `clk` input 1: single clock; all state changes on the rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `in_valid` input 1: input beat present
- `in_ready` output 1: input beat accepted when `in_valid && in_ready`
- `in_data` input WIDTH: beat payload
- `in_sel` input SELW: destination channel; sampled only on the first beat of a packet
- `in_last` input 1: final beat of the packet
- `out_valid` output N: bit i is the valid for channel i; at most one bit set
- `out_ready` input N: bit i is the ready for channel i
- `out_data` output N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH]
- `out_last` output N: bit i is the last flag for channel i
- `drop_cnt` output 16: count of dropped packets, saturating

## Operation
- Holding register: `full`, `dst` (SELW bits), `dreg` (WIDTH bits), `lreg` (1 bit).
- `out_valid[i] = full && dst==i`.
- `out_data` slice i = `dreg` when `full && dst==i`, else 0. `out_last[i]` follows the same rule.
- Drain: when `out_valid[dst] && out_ready[dst]`, the beat leaves. `full` clears unless a new beat loads in the same cycle.
- Ready rule, with `in_ready` independent of `in_valid`, `in_data` and `in_last`:
  - In IDLE, `in_ready = 1` if `in_sel >= N`; otherwise `in_ready = !full || out_ready[dst]`.
  - In PKT, `in_ready = !full || out_ready[dst]`.
  - In DROP, `in_ready = 1`.
- FSM states: IDLE, PKT, DROP. Transitions happen on an accepted beat only.
  - IDLE, `in_sel < N`: load `dreg`/`lreg`, set `dst = in_sel`, set `full`. Go to PKT if `!in_last`, else stay in IDLE.
  - IDLE, `in_sel >= N`: discard the beat. `drop_cnt` += 1, saturating at 16'hFFFF. Go to DROP if `!in_last`, else stay in IDLE.
  - PKT: load the beat to `dst`; `in_sel` is ignored. Return to IDLE on `in_last`.
  - DROP: discard the beat; `in_sel` is ignored. Return to IDLE on `in_last`. `drop_cnt` does not increment here.
- A new packet to a different channel may load in the same cycle the previous beat drains. This is legal because `dst` updates with the load.
- Simultaneous drain and load: `full` stays 1; `dreg`, `lreg` and `dst` take the new beat.

## Timing
- Latency: an accepted input beat appears on `out_valid` the next cycle.
- Throughput: 1 beat/cycle while the destination keeps `out_ready` high.
- Output stability: the holding register changes only on a load. A presented `out_data`/`out_last` is stable until its handshake completes.
- Reset (asynchronous assert, synchronous release):
  - `full = 0`, state = IDLE, `dst = 0`, `dreg = 0`, `lreg = 0`, `drop_cnt = 0`.
  - Hence `out_valid = 0`, `out_data = 0`, `out_last = 0`.
  - `in_ready` after reset = 1 (register empty).
- Reset mid-packet: the packet is truncated and the held beat is lost. The next accepted beat is treated as a packet start.
- `drop_cnt` holds at 0xFFFF once saturated; it is cleared only by reset.

## Test plan
- Reset then idle, N=8 WIDTH=8:
  - All outputs are 0 and `in_ready=1`.
  - Assert `rst_n=0` mid-cycle; outputs clear before the next edge.
- Single-beat packets to sel 0..7 with data 0xA0+sel, `out_ready` all 1:
  - Each beat appears on exactly channel sel one cycle later.
  - All other slices read 0.
- 4-beat packet to sel 5 where `in_sel` changes to 2 on beats 2-4:
  - All four beats go to channel 5, with `out_last[5]` on beat 4.
  - The following packet with sel 2 lands on channel 2.
- Backpressure: packet to sel 3, `out_ready[3]=0` for 3 cycles while `out_ready` is 1 elsewhere:
  - `in_ready=0` for those cycles and `out_data` is held.
  - No beat is lost or duplicated, and throughput is 1/cycle after release.
- N=6, packets with sel 7 (3 beats), then sel 6 (1 beat), then sel 1:
  - Both invalid packets are consumed with `in_ready=1` and no `out_valid`.
  - `drop_cnt=2`, and the sel 1 packet is delivered.
- Back-to-back packets to channels 1 then 4 with continuous `in_valid` and all ready:
  - No bubble between them.
  - `out_valid` moves from bit 1 to bit 4 on consecutive cycles.
